// File: rtl/seq_adder.sv
// Digit-serial adder: adds DIGIT bits of A+B per clock, LSB slice first,
// and publishes sum/cout/ovf only when the last slice completes.
module seq_adder #(
    parameter int WIDTH  = 8,
    parameter int DIGIT  = 1,
    parameter int SIGNED = 0
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] sum,
    output logic             cout,
    output logic             ovf
);

    localparam int N  = WIDTH / DIGIT;
    localparam int CW = (N > 1) ? $clog2(N) : 1;
    localparam logic [CW-1:0] LAST = CW'(N - 1);

    localparam logic [0:0] S_IDLE = 1'b0;
    localparam logic [0:0] S_RUN  = 1'b1;

    logic [0:0]       state_q, state_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic [WIDTH-1:0] a_q, a_d;
    logic [WIDTH-1:0] b_q, b_d;
    logic             carry_q, carry_d;
    logic [WIDTH-1:0] sum_q, sum_d;
    logic             cout_q, cout_d;
    logic             ovf_q, ovf_d;
    logic             done_q, done_d;

    logic [DIGIT:0]   slice;
    logic [WIDTH-1:0] acc_next;
    logic             c_into_msb;
    logic             last;

    // a_q doubles as the result accumulator: each slice result enters at
    // the top while the consumed operand slice leaves at the bottom.
    always_comb begin
        slice = {1'b0, a_q[DIGIT-1:0]}
              + {1'b0, b_q[DIGIT-1:0]}
              + {{DIGIT{1'b0}}, carry_q};
        acc_next = (a_q >> DIGIT)
                 | (WIDTH'(slice[DIGIT-1:0]) << (WIDTH - DIGIT));
        c_into_msb = a_q[DIGIT-1] ^ b_q[DIGIT-1] ^ slice[DIGIT-1];
        last = (cnt_q == LAST);
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        a_d     = a_q;
        b_d     = b_q;
        carry_d = carry_q;
        sum_d   = sum_q;
        cout_d  = cout_q;
        ovf_d   = ovf_q;
        done_d  = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (start) begin
                    state_d = S_RUN;
                    cnt_d   = '0;
                    a_d     = a;
                    b_d     = b;
                    carry_d = cin;
                end
            end
            S_RUN: begin
                a_d     = acc_next;
                b_d     = b_q >> DIGIT;
                carry_d = slice[DIGIT];
                cnt_d   = cnt_q + CW'(1);
                if (last) begin
                    state_d = S_IDLE;
                    cnt_d   = '0;
                    carry_d = 1'b0;
                    sum_d   = acc_next;
                    cout_d  = slice[DIGIT];
                    // Signed overflow: carry into MSB differs from carry out.
                    ovf_d   = (SIGNED != 0) ? (c_into_msb ^ slice[DIGIT])
                                            : slice[DIGIT];
                    done_d  = 1'b1;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
            a_q     <= '0;
            b_q     <= '0;
            carry_q <= 1'b0;
            sum_q   <= '0;
            cout_q  <= 1'b0;
            ovf_q   <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            a_q     <= a_d;
            b_q     <= b_d;
            carry_q <= carry_d;
            sum_q   <= sum_d;
            cout_q  <= cout_d;
            ovf_q   <= ovf_d;
            done_q  <= done_d;
        end
    end

    assign busy = (state_q == S_RUN);
    assign done = done_q;
    assign sum  = sum_q;
    assign cout = cout_q;
    assign ovf  = ovf_q;

endmodule

// File: tb/tb_seq_adder.sv
// Directed bench for seq_adder across bit-serial, signed, 4-bit-digit
// and single-cycle configurations.
module tb_seq_adder;

    logic       clk = 1'b0;
    logic       rst;
    logic       start [4];
    logic [7:0] a     [4];
    logic [7:0] b     [4];
    logic       cin   [4];
    logic       busy  [4];
    logic       done  [4];
    logic [7:0] sum   [4];
    logic       cout  [4];
    logic       ovf   [4];

    int total = 0;
    int bad   = 0;

    int         nlat [4] = '{8, 8, 2, 1};
    logic [7:0] prev_sum  [4];
    logic       prev_cout [4];
    logic       prev_ovf  [4];

    always #5 clk = ~clk;

    seq_adder #(.WIDTH(8), .DIGIT(1), .SIGNED(0)) u_u8 (
        .clk(clk), .rst(rst), .start(start[0]), .a(a[0]), .b(b[0]),
        .cin(cin[0]), .busy(busy[0]), .done(done[0]), .sum(sum[0]),
        .cout(cout[0]), .ovf(ovf[0]));

    seq_adder #(.WIDTH(8), .DIGIT(1), .SIGNED(1)) u_s8 (
        .clk(clk), .rst(rst), .start(start[1]), .a(a[1]), .b(b[1]),
        .cin(cin[1]), .busy(busy[1]), .done(done[1]), .sum(sum[1]),
        .cout(cout[1]), .ovf(ovf[1]));

    seq_adder #(.WIDTH(8), .DIGIT(4), .SIGNED(0)) u_d4 (
        .clk(clk), .rst(rst), .start(start[2]), .a(a[2]), .b(b[2]),
        .cin(cin[2]), .busy(busy[2]), .done(done[2]), .sum(sum[2]),
        .cout(cout[2]), .ovf(ovf[2]));

    seq_adder #(.WIDTH(8), .DIGIT(8), .SIGNED(1)) u_d8 (
        .clk(clk), .rst(rst), .start(start[3]), .a(a[3]), .b(b[3]),
        .cin(cin[3]), .busy(busy[3]), .done(done[3]), .sum(sum[3]),
        .cout(cout[3]), .ovf(ovf[3]));

    typedef struct {
        int         d;
        logic [7:0] a;
        logic [7:0] b;
        logic       ci;
        logic [7:0] s;
        logic       co;
        logic       ov;
    } vec_t;

    vec_t vecs [15];

    task automatic chk(input string nm, input logic [63:0] act,
                       input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h want %0h", nm, act, exp);
        end
    endtask

    // Called at a negedge; drives the request immediately.
    task automatic run_op(input int d, input logic [7:0] av,
                          input logic [7:0] bv, input logic ci,
                          input logic [7:0] es, input logic eco,
                          input logic eov, input string nm);
        int cyc = 0;
        bit busy_ok = 1'b1;
        bit hold_ok = 1'b1;
        start[d] = 1'b1;
        a[d] = av;
        b[d] = bv;
        cin[d] = ci;
        for (int c = 1; c <= 20; c++) begin
            @(negedge clk);
            if (c == 1) begin
                start[d] = 1'b0;
                a[d] = ~av;
                b[d] = ~bv;
                cin[d] = ~ci;
            end
            if (done[d]) begin
                cyc = c;
                break;
            end
            if (!busy[d]) busy_ok = 1'b0;
            if (sum[d] !== prev_sum[d] || cout[d] !== prev_cout[d] ||
                ovf[d] !== prev_ovf[d]) hold_ok = 1'b0;
        end
        chk({nm, " latency"}, 64'(cyc), 64'(nlat[d] + 1));
        chk({nm, " busy_run"}, 64'(busy_ok), 64'd1);
        chk({nm, " hold"}, 64'(hold_ok), 64'd1);
        chk({nm, " busy_done"}, 64'(busy[d]), 64'd0);
        chk({nm, " result"}, {54'd0, sum[d], cout[d], ovf[d]},
            {54'd0, es, eco, eov});
        prev_sum[d]  = es;
        prev_cout[d] = eco;
        prev_ovf[d]  = eov;
    endtask

    initial begin
        int pulses;
        int first_at;
        int second_at;

        vecs[0]  = '{0, 8'h00, 8'h00, 1'b1, 8'h01, 1'b0, 1'b0};
        vecs[1]  = '{0, 8'hFF, 8'h00, 1'b1, 8'h00, 1'b1, 1'b1};
        vecs[2]  = '{0, 8'h55, 8'hAA, 1'b0, 8'hFF, 1'b0, 1'b0};
        vecs[3]  = '{0, 8'hFF, 8'hFF, 1'b1, 8'hFF, 1'b1, 1'b1};
        vecs[4]  = '{0, 8'h12, 8'h34, 1'b0, 8'h46, 1'b0, 1'b0};
        vecs[5]  = '{1, 8'h80, 8'h80, 1'b0, 8'h00, 1'b1, 1'b1};
        vecs[6]  = '{1, 8'h7F, 8'h01, 1'b0, 8'h80, 1'b0, 1'b1};
        vecs[7]  = '{1, 8'hFF, 8'h01, 1'b0, 8'h00, 1'b1, 1'b0};
        vecs[8]  = '{1, 8'h40, 8'h40, 1'b0, 8'h80, 1'b0, 1'b1};
        vecs[9]  = '{1, 8'hC0, 8'hC0, 1'b0, 8'h80, 1'b1, 1'b0};
        vecs[10] = '{2, 8'h3C, 8'h0F, 1'b0, 8'h4B, 1'b0, 1'b0};
        vecs[11] = '{2, 8'h01, 8'h01, 1'b0, 8'h02, 1'b0, 1'b0};
        vecs[12] = '{2, 8'hF0, 8'h10, 1'b0, 8'h00, 1'b1, 1'b1};
        vecs[13] = '{3, 8'h7F, 8'h00, 1'b1, 8'h80, 1'b0, 1'b1};
        vecs[14] = '{3, 8'h01, 8'hFF, 1'b0, 8'h00, 1'b1, 1'b0};

        rst = 1'b1;
        for (int i = 0; i < 4; i++) begin
            start[i] = 1'b1;
            a[i] = 8'hA5;
            b[i] = 8'h5A;
            cin[i] = 1'b1;
            prev_sum[i] = 8'h00;
            prev_cout[i] = 1'b0;
            prev_ovf[i] = 1'b0;
        end
        repeat (3) @(negedge clk);
        for (int i = 0; i < 4; i++) begin
            chk($sformatf("reset_state%0d", i),
                {52'd0, busy[i], done[i], sum[i], cout[i], ovf[i]}, 64'd0);
            start[i] = 1'b0;
        end
        rst = 1'b0;
        @(negedge clk);

        for (int i = 0; i < 15; i++)
            run_op(vecs[i].d, vecs[i].a, vecs[i].b, vecs[i].ci,
                   vecs[i].s, vecs[i].co, vecs[i].ov,
                   $sformatf("vec%0d", i));
        @(negedge clk);
        chk("done_single", 64'(done[3]), 64'd0);

        run_op(2, 8'h3C, 8'h0F, 1'b0, 8'h4B, 1'b0, 1'b0, "b2b_first");
        run_op(2, 8'h01, 8'h01, 1'b0, 8'h02, 1'b0, 1'b0, "b2b_second");
        @(negedge clk);
        chk("b2b_done_once", 64'(done[2]), 64'd0);

        // Start held high; operands scrambled while running.
        pulses = 0;
        first_at = 0;
        second_at = 0;
        start[0] = 1'b1;
        a[0] = 8'h11;
        b[0] = 8'h22;
        cin[0] = 1'b0;
        for (int c = 1; c <= 18; c++) begin
            @(negedge clk);
            if (done[0]) begin
                pulses++;
                if (pulses == 1) first_at = c;
                if (pulses == 2) second_at = c;
                chk($sformatf("hold_sum%0d", pulses), 64'(sum[0]), 64'h33);
                a[0] = 8'h11;
                b[0] = 8'h22;
                cin[0] = 1'b0;
            end else begin
                a[0] = 8'($urandom);
                b[0] = 8'($urandom);
                cin[0] = 1'($urandom);
            end
        end
        start[0] = 1'b0;
        chk("hold_pulses", 64'(pulses), 64'd2);
        chk("hold_first", 64'(first_at), 64'd9);
        chk("hold_second", 64'(second_at), 64'd18);
        repeat (2) @(negedge clk);

        // Reset in the third RUN cycle.
        start[0] = 1'b1;
        a[0] = 8'hFF;
        b[0] = 8'hFF;
        cin[0] = 1'b1;
        @(negedge clk);
        start[0] = 1'b0;
        @(negedge clk);
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        chk("abort_state", {53'd0, busy[0], done[0], sum[0], cout[0], ovf[0]},
            64'd0);
        pulses = 0;
        for (int c = 0; c < 12; c++) begin
            @(negedge clk);
            if (done[0] || sum[0] !== 8'h00) pulses++;
        end
        chk("abort_no_done", 64'(pulses), 64'd0);
        for (int i = 0; i < 4; i++) begin
            prev_sum[i] = 8'h00;
            prev_cout[i] = 1'b0;
            prev_ovf[i] = 1'b0;
        end
        run_op(0, 8'h00, 8'h00, 1'b1, 8'h01, 1'b0, 1'b0, "post_rst");

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
